debounce_scan_ctrl: RTL and testbench
=====================================

// Module: debounce_scan_ctrl
// PURPOSE
//   Time-multiplexed debounce scheduler for N_CH push-buttons. One shared tick divider and one
//   compare/count datapath are sequenced across all channels. The block keeps a stable level per
//   channel and queues debounced press (0->1) events. A round-robin arbiter hands the events to
//   a single valid/ready consumer port. It sits between the board button pins and the control FSMs.
// PARAMETERS
//   N_CH        4       number of button channels (>=2)
//   TICK_DIV    100000  clocks per sample tick; must be >= N_CH+2 (checked by assertion)
//   STABLE_CNT  8       consecutive differing samples required to accept a new level (>=1)
// PORTS
//   clock       in   1          system clock, all logic on rising edge
//   reset       in   1          asynchronous, active-high; clears all state
//   raw_in      in   N_CH       raw button pins, asynchronous
//   level_out   out  N_CH       debounced levels
//   ev_valid    out  1          press event available
//   ev_ch       out  IDXW       channel index of event, IDXW=$clog2(N_CH)
//   ev_ready    in   1          consumer accepts event when ev_valid&&ev_ready
//   ev_overrun  out  1          1-cycle pulse: press detected while same channel already pending
//   scan_busy   out  1          high while FSM is in SCAN
// BEHAVIOUR
//   - Reset: level_out=0, ev_valid=0, ev_ch=0, ev_overrun=0, scan_busy=0, tick counter=0,
//     all per-channel counts=0, pending=0, RR pointer=0, FSM=IDLE. Reset mid-scan or mid-handshake
//     drops everything immediately; there is no resume.
//   - raw_in goes through a 2-flop synchronizer (sync_in) before any use.
//   - Tick: counter runs 0..TICK_DIV-1 and wraps; tick=1 for one clock at the wrap.
//   - FSM IDLE: tick -> SCAN, idx=0. SCAN: process channel idx in one clock; idx==N_CH-1 -> IDLE,
//     else idx+1. A tick seen in SCAN is ignored (cannot occur under the TICK_DIV constraint).
//   - Per-channel step (channel idx, s=sync_in[idx], L=level_out[idx], c=cnt[idx]):
//       s==L        : c<=0
//       s!=L, c+1<STABLE_CNT : c<=c+1
//       s!=L, c+1==STABLE_CNT: level_out[idx]<=s, c<=0; if s==1 set pending[idx]
//     Count width CW=$clog2(STABLE_CNT+1); it never exceeds STABLE_CNT-1 when stored.
//     A new level is therefore accepted on the STABLE_CNT-th consecutive differing tick and is
//     visible on level_out the clock after that channel's SCAN cycle.
//   - Press while pending[idx] already 1: events coalesce (pending stays 1) and ev_overrun pulses.
//   - Event output (registered): when ev_valid==0 or (ev_valid&&ev_ready), if pending!=0 load the
//     first set channel at or after RR pointer (wrapping): ev_ch<=ch, ev_valid<=1, pending[ch]<=0,
//     pointer<=ch+1 mod N_CH; else ev_valid<=0. A same-cycle set of pending[ch] by SCAN and clear
//     by load leaves pending[ch]=1 (second press is kept, no overrun).
//   - While ev_valid&&!ev_ready: ev_ch and ev_valid are held stable.
//   - Minimum latency: pending set at edge k -> ev_valid=1 at edge k+1.
//   - Release (1->0) updates level_out only; it generates no event.
// STRUCTURE
//   - debounce_pkg: FSM state enum {IDLE,SCAN}; localparam functions for IDXW/CW.
//   - Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs gnt_valid and gnt_idx
//     (combinational). It is instanced once for event selection.
//   - Tick divider, synchronizer, scan FSM and per-channel count/level registers stay in the top.
// TESTING (N_CH=4, TICK_DIV=8, STABLE_CNT=3)
//   1 Reset pulse at random time with raw_in=4'hF -> all outputs 0 next edge; no event until 3 ticks
//     after release, then level_out=4'hF.
//   2 raw_in[1] toggles each tick for 10 ticks, then held 1 -> level_out[1] rises exactly on the
//     3rd stable tick; exactly one event with ev_ch=1.
//   3 ch0 and ch2 pressed same tick, ev_ready=0 for 20 clocks then 1 -> ev_ch=0 held stable through
//     stall, then ch2 on next clock; no extra events.
//   4 ch0 and ch3 pressed repeatedly, ev_ready=1 -> grants alternate 0,3,0,3 (RR pointer fairness).
//   5 ch2 press, release, press with ev_ready=0 -> one ev_overrun pulse, single ch2 event delivered.
//   6 Reset during SCAN with ev_valid=1 -> ev_valid=0 and scan_busy=0 at once; pending lost.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the time-multiplexed button debounce scheduler.
package debounce_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned stable);
        return $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping modulo N.
module rr_arbiter
    import debounce_pkg::*;
#(
    parameter int unsigned  N  = 4,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [N-1:0]  w_rot;
    logic [IW-1:0] w_off;
    logic [IW:0]   w_sum;

    // Rotate so bit 0 is the pointer position, then take the lowest set offset.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_off     = '0;
        w_rot     = N'({req, req} >> ptr);
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                gnt_valid = 1'b1;
                w_off     = IW'(k);
            end
        end
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= (IW + 1)'(N)) begin
            gnt_idx = IW'(w_sum - (IW + 1)'(N));
        end else begin
            gnt_idx = IW'(w_sum);
        end
    end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Debounce scheduler: one shared tick and count datapath walked across N_CH buttons,
// press events queued per channel and handed out round-robin on a valid/ready port.
module debounce_scan_ctrl
    import debounce_pkg::*;
#(
    parameter int unsigned  N_CH       = 4,
    parameter int unsigned  TICK_DIV   = 100000,
    parameter int unsigned  STABLE_CNT = 8,
    localparam int unsigned IDXW       = idx_width(N_CH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level_out,
    output logic            ev_valid,
    output logic [IDXW-1:0] ev_ch,
    input  logic            ev_ready,
    output logic            ev_overrun,
    output logic            scan_busy
);

    localparam int unsigned CW = cnt_width(STABLE_CNT);
    localparam int unsigned TW = $clog2(TICK_DIV);

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [TW-1:0]   r_tick_cnt;
    logic            w_tick;
    scan_state_t     r_state;
    scan_state_t     w_state_nxt;
    logic [IDXW-1:0] r_idx;
    logic [IDXW-1:0] w_idx_nxt;
    logic [CW-1:0]   r_cnt [N_CH];
    logic [N_CH-1:0] r_level;
    logic [N_CH-1:0] r_pending;
    logic [IDXW-1:0] r_ptr;
    logic            r_ev_valid;
    logic [IDXW-1:0] r_ev_ch;
    logic            r_ev_overrun;

    logic            w_scan_en;
    logic            w_s;
    logic            w_l;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_differ;
    logic            w_accept;
    logic            w_press;
    logic [N_CH-1:0] w_set;
    logic [N_CH-1:0] w_clr;
    logic            w_load_en;
    logic            w_overrun;
    logic            w_gnt_valid;
    logic [IDXW-1:0] w_gnt_idx;

    assign level_out  = r_level;
    assign ev_valid   = r_ev_valid;
    assign ev_ch      = r_ev_ch;
    assign ev_overrun = r_ev_overrun;
    assign scan_busy  = (r_state == SCAN);

    // Two-flop synchronizer and free-running sample tick divider.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_sync1    <= raw_in;
            r_sync2    <= r_sync1;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
        end
    end

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // A tick arriving mid-scan is dropped; the divider constraint keeps it from happening.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    w_state_nxt = SCAN;
                    w_idx_nxt   = '0;
                end
            end
            SCAN: begin
                if (r_idx == IDXW'(N_CH - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_idx_nxt = r_idx + IDXW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shared compare/count step for the channel under the scan index, plus event bookkeeping.
    always_comb begin
        w_scan_en = (r_state == SCAN);
        w_s       = r_sync2[r_idx];
        w_l       = r_level[r_idx];
        w_cnt_inc = r_cnt[r_idx] + CW'(1);
        w_differ  = w_scan_en && (w_s != w_l);
        w_accept  = w_differ && (w_cnt_inc == CW'(STABLE_CNT));
        w_press   = w_accept && w_s;
        w_set     = w_press ? (N_CH'(1) << r_idx) : '0;
        w_load_en = !r_ev_valid || ev_ready;
        w_clr     = (w_load_en && w_gnt_valid) ? (N_CH'(1) << w_gnt_idx) : '0;
        w_overrun = |(w_set & r_pending & ~w_clr);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_level <= '0;
        end else if (w_scan_en) begin
            if (!w_differ) begin
                r_cnt[r_idx] <= '0;
            end else if (w_accept) begin
                r_cnt[r_idx]   <= '0;
                r_level[r_idx] <= w_s;
            end else begin
                r_cnt[r_idx] <= w_cnt_inc;
            end
        end
    end

    rr_arbiter #(
        .N (N_CH)
    ) u_rr_arbiter (
        .req       (r_pending),
        .ptr       (r_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    // Set wins over clear so a press landing on the load cycle is kept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending    <= '0;
            r_ptr        <= '0;
            r_ev_valid   <= 1'b0;
            r_ev_ch      <= '0;
            r_ev_overrun <= 1'b0;
        end else begin
            r_pending    <= (r_pending & ~w_clr) | w_set;
            r_ev_overrun <= w_overrun;
            if (w_load_en) begin
                if (w_gnt_valid) begin
                    r_ev_valid <= 1'b1;
                    r_ev_ch    <= w_gnt_idx;
                    r_ptr      <= (w_gnt_idx == IDXW'(N_CH - 1)) ? '0 : w_gnt_idx + IDXW'(1);
                end else begin
                    r_ev_valid <= 1'b0;
                end
            end
        end
    end

    a_tick_div_min: assert property (@(posedge clock) disable iff (reset) (TICK_DIV >= N_CH + 2));

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl: edge-indexed reference model compared every cycle,
// plus directed scenarios with hand-derived event sequences.
module tb_debounce_scan_ctrl;

    localparam int N_CH = 4;
    localparam int TD   = 8;
    localparam int SC   = 3;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic [3:0] raw_in   = 4'h0;
    logic       ev_ready = 1'b1;
    logic [3:0] level_out;
    logic       ev_valid;
    logic [1:0] ev_ch;
    logic       ev_overrun;
    logic       scan_busy;

    debounce_scan_ctrl #(
        .N_CH       (N_CH),
        .TICK_DIV   (TD),
        .STABLE_CNT (SC)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .raw_in     (raw_in),
        .level_out  (level_out),
        .ev_valid   (ev_valid),
        .ev_ch      (ev_ch),
        .ev_ready   (ev_ready),
        .ev_overrun (ev_overrun),
        .scan_busy  (scan_busy)
    );

    always #5 clock = ~clock;

    int checks  = 0;
    int errors  = 0;
    int ovr_cnt = 0;
    int ev_log[$];
    int exp_q[$];

    // Reference model state, indexed by edges counted since reset release.
    int         m_edge;
    logic [3:0] m_r1, m_r2;
    logic [3:0] m_level, m_pend;
    int         m_cnt[4];
    logic       m_valid;
    int         m_ch;
    int         m_ptr;
    logic       m_ovr;
    logic       m_scan;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, m_edge, $time);
        end
    endtask

    always @(posedge clock or posedge reset) begin : model
        logic [3:0] set_v, clr_v;
        int         c, ch;
        logic       s, found;
        if (reset) begin
            m_edge  = 0;
            m_r1    = '0;
            m_r2    = '0;
            m_level = '0;
            m_pend  = '0;
            for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
            m_valid = 1'b0;
            m_ch    = 0;
            m_ptr   = 0;
            m_ovr   = 1'b0;
            m_scan  = 1'b0;
        end else begin
            m_edge++;
            set_v = '0;
            clr_v = '0;
            // Channel c is judged one edge after the scan visits it, on raw seen two edges back.
            if (m_edge >= TD + 1 && (m_edge - 1) % TD < N_CH) begin
                c = (m_edge - 1) % TD;
                s = m_r2[c];
                if (s == m_level[c]) m_cnt[c] = 0;
                else if (m_cnt[c] + 1 < SC) m_cnt[c] = m_cnt[c] + 1;
                else begin
                    m_level[c] = s;
                    m_cnt[c]   = 0;
                    set_v[c]   = s;
                end
            end
            if (!m_valid || ev_ready) begin
                found = 1'b0;
                for (int i = 0; i < N_CH; i++) begin
                    ch = (m_ptr + i) % N_CH;
                    if (!found && m_pend[ch]) begin
                        found     = 1'b1;
                        m_ch      = ch;
                        clr_v[ch] = 1'b1;
                    end
                end
                if (found) m_ptr = (m_ch + 1) % N_CH;
                m_valid = found;
            end
            m_ovr  = |(set_v & m_pend & ~clr_v);
            m_pend = (m_pend & ~clr_v) | set_v;
            m_scan = (m_edge >= TD) && (m_edge % TD < N_CH);
            m_r2   = m_r1;
            m_r1   = raw_in;
        end
    end

    always @(negedge clock) begin
        chk("level_out", 32'(level_out), 32'(m_level));
        chk("ev_valid", 32'(ev_valid), 32'(m_valid));
        chk("ev_ch", 32'(ev_ch), 32'(m_ch));
        chk("ev_overrun", 32'(ev_overrun), 32'(m_ovr));
        chk("scan_busy", 32'(scan_busy), 32'(m_scan));
        if (ev_overrun) ovr_cnt++;
    end

    always @(posedge clock) begin
        if (!reset && ev_valid && ev_ready) ev_log.push_back(int'(ev_ch));
    end

    task automatic wait_phase4();
        int guard;
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while ((m_edge % TD != 4) && guard < 4 * TD);
        if (guard >= 4 * TD) begin
            checks++;
            errors++;
            $display("FAIL phase_wait: edge %0d never reached tick phase 4", m_edge);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_phase4();
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        ev_log.delete();
        ovr_cnt = 0;
    endtask

    task automatic chk_log(input string name);
        chk({name, "_count"}, 32'(ev_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < ev_log.size(); i++) begin
            chk(name, 32'(ev_log[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        raw_in   = 4'hF;
        ev_ready = 1'b1;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;

        // 1: reset pulse at a random point with all buttons held
        wait_ticks(2);
        @(negedge clock);
        #($urandom_range(1, 3)) reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_level_out", 32'(level_out), 32'h0);
        chk("rst_ev_valid", 32'(ev_valid), 32'h0);
        chk("rst_ev_ch", 32'(ev_ch), 32'h0);
        chk("rst_ev_overrun", 32'(ev_overrun), 32'h0);
        chk("rst_scan_busy", 32'(scan_busy), 32'h0);
        @(negedge clock);
        #2 reset = 1'b0;
        ev_log.delete();
        wait_ticks(3);
        chk("t1_level_before", 32'(level_out), 32'h0);
        chk("t1_no_event_yet", 32'(ev_log.size()), 32'h0);
        wait_phase4();
        chk("t1_level_after", 32'(level_out), 32'hF);
        wait_phase4();
        exp_q = '{0, 1, 2, 3};
        chk_log("t1_events");

        // 2: channel 1 chatters for ten ticks then settles high
        raw_in = 4'h0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            wait_phase4();
            raw_in[1] = (i % 2 == 0);
        end
        wait_phase4();
        raw_in[1] = 1'b1;
        wait_ticks(2);
        chk("t2_level_2nd_tick", 32'(level_out), 32'h0);
        wait_phase4();
        chk("t2_level_3rd_tick", 32'(level_out), 32'h2);
        wait_phase4();
        exp_q = '{1};
        chk_log("t2_events");

        // 3: simultaneous presses on 0 and 2 with consumer stalled
        raw_in = 4'h0;
        apply_reset();
        ev_ready = 1'b0;
        wait_phase4();
        raw_in = 4'b0101;
        wait_ticks(3);
        repeat (20) @(negedge clock);
        chk("t3_stall_valid", 32'(ev_valid), 32'h1);
        chk("t3_stall_ch", 32'(ev_ch), 32'h0);
        chk("t3_stall_no_accept", 32'(ev_log.size()), 32'h0);
        ev_ready = 1'b1;
        @(negedge clock);
        chk("t3_next_valid", 32'(ev_valid), 32'h1);
        chk("t3_next_ch", 32'(ev_ch), 32'h2);
        wait_ticks(2);
        exp_q = '{0, 2};
        chk_log("t3_events");

        // 4: repeated presses on channels 0 and 3
        raw_in = 4'h0;
        apply_reset();
        ev_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            wait_phase4();
            raw_in = 4'b1001;
            wait_ticks(3);
            raw_in = 4'b0000;
            wait_ticks(3);
        end
        wait_ticks(1);
        exp_q = '{0, 3, 0, 3};
        chk_log("t4_events");

        // 5: channel 2 re-pressed while its first press is still queued
        raw_in = 4'h0;
        apply_reset();
        ev_ready = 1'b0;
        wait_phase4();
        raw_in = 4'b0101;
        wait_ticks(4);
        raw_in = 4'b0001;
        wait_ticks(4);
        raw_in = 4'b0101;
        wait_ticks(4);
        chk("t5_overrun_pulses", 32'(ovr_cnt), 32'h1);
        chk("t5_held_ch", 32'(ev_ch), 32'h0);
        ev_ready = 1'b1;
        wait_ticks(1);
        exp_q = '{0, 2};
        chk_log("t5_events");
        chk("t5_level", 32'(level_out), 32'h5);

        // 6: reset in the middle of a scan with an event on the port
        raw_in = 4'h0;
        apply_reset();
        ev_ready = 1'b0;
        wait_phase4();
        raw_in = 4'b0101;
        wait_ticks(3);
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (!(m_edge >= TD && m_edge % TD == 1) && guard < 4 * TD);
        chk("t6_pre_scan", 32'(scan_busy), 32'h1);
        chk("t6_pre_valid", 32'(ev_valid), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(ev_valid), 32'h0);
        chk("t6_rst_scan", 32'(scan_busy), 32'h0);
        chk("t6_rst_level", 32'(level_out), 32'h0);
        raw_in = 4'h0;
        @(negedge clock);
        #2 reset = 1'b0;
        ev_log.delete();
        ev_ready = 1'b1;
        wait_ticks(5);
        chk("t6_pending_lost", 32'(ev_log.size()), 32'h0);
        chk("t6_level", 32'(level_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
